// File: rtl/tl_link_top.sv
// tl_link_top: self-contained TileLink-UL subsystem.
//   An L1 master adapter turns single commands into A-channel requests and
//   collects the D-channel response. An L2 slave adapter serves those requests
//   from an internal 1024 x 64-bit word memory.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   start_transaction, transaction_type, address, size, source,
//   write_data, write_mask          command inputs (type 0 GET, 1 PUTFULL,
//                                   2 PUTPARTIAL, 3 reserved / no-op)
//   transaction_done, read_data     completion pulse, data of last GET
//   mem_write_*, mem_read_*         one-cycle memory access monitor strobes
//   resp_*                          D-channel handshake monitor
// Build option:
//   TL_LINK_BUFFER_EN               inserts a one-entry register slice on the A
//                                   and D channels between the L1 and L2 nets
//                                   (completion latency 5 cycles instead of 3).

package tl_link_pkg;
    localparam int unsigned TL_ADDR_BITS   = 32;
    localparam int unsigned TL_SIZE_BITS   = 3;
    localparam int unsigned TL_SOURCE_BITS = 4;
    localparam int unsigned TL_DATA_BYTES  = 8;
    localparam int unsigned TL_DATA_BITS   = TL_DATA_BYTES * 8;
    localparam int unsigned TL_MEM_DEPTH   = 1024;
    localparam int unsigned TL_IDX_BITS    = 10;
    localparam int unsigned TL_OFS_BITS    = 3;

    localparam logic [3:0] A_GET         = 4'd4;
    localparam logic [3:0] A_PUT_FULL    = 4'd0;
    localparam logic [3:0] A_PUT_PARTIAL = 4'd1;
    localparam logic [3:0] D_ACK         = 4'd0;
    localparam logic [3:0] D_ACK_DATA    = 4'd1;

    localparam logic [TL_DATA_BITS-1:0] MEM_INIT_TAG = 64'hC0DE_0000_0000_0000;

    typedef struct packed {
        logic [3:0]                opcode;
        logic [TL_SOURCE_BITS-1:0] source;
        logic [TL_ADDR_BITS-1:0]   address;
        logic [TL_DATA_BYTES-1:0]  mask;
        logic [TL_DATA_BITS-1:0]   data;
    } a_chan_t;

    typedef struct packed {
        logic [3:0]                opcode;
        logic [TL_SOURCE_BITS-1:0] source;
        logic [TL_DATA_BITS-1:0]   data;
    } d_chan_t;
endpackage

module tl_link_top
    import tl_link_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_transaction,
    input  logic [1:0]                transaction_type,
    output logic                      transaction_done,
    input  logic [TL_ADDR_BITS-1:0]   address,
    input  logic [TL_SIZE_BITS-1:0]   size,
    input  logic [TL_SOURCE_BITS-1:0] source,
    input  logic [TL_DATA_BITS-1:0]   write_data,
    input  logic [TL_DATA_BYTES-1:0]  write_mask,
    output logic [TL_DATA_BITS-1:0]   read_data,
    output logic                      mem_write_valid,
    output logic [TL_ADDR_BITS-1:0]   mem_write_addr,
    output logic [TL_DATA_BITS-1:0]   mem_write_data,
    output logic [TL_DATA_BYTES-1:0]  mem_write_mask,
    output logic                      mem_read_valid,
    output logic [TL_ADDR_BITS-1:0]   mem_read_addr,
    output logic [TL_DATA_BITS-1:0]   mem_read_data,
    output logic                      resp_valid,
    output logic [3:0]                resp_opcode,
    output logic [TL_SOURCE_BITS-1:0] resp_source,
    output logic [TL_DATA_BITS-1:0]   resp_data
);

    // ---------------- channel nets ----------------
    logic                      l1_a_valid, l1_a_ready;
    logic [3:0]                l1_a_opcode;
    logic [TL_SOURCE_BITS-1:0] l1_a_source;
    logic [TL_ADDR_BITS-1:0]   l1_a_address;
    logic [TL_DATA_BYTES-1:0]  l1_a_mask;
    logic [TL_DATA_BITS-1:0]   l1_a_data;
    logic                      l1_d_valid, l1_d_ready;
    logic [3:0]                l1_d_opcode;
    logic [TL_SOURCE_BITS-1:0] l1_d_source;
    logic [TL_DATA_BITS-1:0]   l1_d_data;

    logic                      l2_a_valid, l2_a_ready;
    logic [3:0]                l2_a_opcode;
    logic [TL_SOURCE_BITS-1:0] l2_a_source;
    logic [TL_ADDR_BITS-1:0]   l2_a_address;
    logic [TL_DATA_BYTES-1:0]  l2_a_mask;
    logic [TL_DATA_BITS-1:0]   l2_a_data;
    logic                      l2_d_valid, l2_d_ready;
    logic [3:0]                l2_d_opcode;
    logic [TL_SOURCE_BITS-1:0] l2_d_source;
    logic [TL_DATA_BITS-1:0]   l2_d_data;

    // ---------------- L1 master adapter ----------------
    typedef enum logic [1:0] {L1_IDLE, L1_REQ, L1_RESP, L1_DONE} l1_state_t;
    l1_state_t l1_state;

    logic [3:0]               cmd_opcode;
    logic [TL_DATA_BYTES-1:0] size_mask;
    logic [TL_DATA_BYTES-1:0] cmd_mask;

    // Opcode and byte lanes for the incoming command.
    always_comb begin
        cmd_opcode = A_GET;
        size_mask  = 8'hFF;
        case (transaction_type)
            2'd1:    cmd_opcode = A_PUT_FULL;
            2'd2:    cmd_opcode = A_PUT_PARTIAL;
            default: cmd_opcode = A_GET;
        endcase
        case (size)
            3'd0:    size_mask = 8'h01;
            3'd1:    size_mask = 8'h03;
            3'd2:    size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
        // Lanes past byte 7 of an unaligned request fall off the word.
        cmd_mask = 8'(size_mask << address[2:0]);
        if (transaction_type == 2'd2) begin
            cmd_mask = write_mask;
        end
    end

    // Command sequencing: issue A beat, wait for D beat, pulse done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l1_state         <= L1_IDLE;
            l1_a_valid       <= 1'b0;
            l1_a_opcode      <= '0;
            l1_a_source      <= '0;
            l1_a_address     <= '0;
            l1_a_mask        <= '0;
            l1_a_data        <= '0;
            l1_d_ready       <= 1'b0;
            read_data        <= '0;
            transaction_done <= 1'b0;
        end else begin
            transaction_done <= 1'b0;
            case (l1_state)
                L1_IDLE: begin
                    if (start_transaction) begin
                        if (transaction_type == 2'd3) begin
                            // Reserved type completes without touching the bus.
                            transaction_done <= 1'b1;
                            l1_state         <= L1_DONE;
                        end else begin
                            l1_a_valid   <= 1'b1;
                            l1_a_opcode  <= cmd_opcode;
                            l1_a_source  <= source;
                            l1_a_address <= address;
                            l1_a_mask    <= cmd_mask;
                            l1_a_data    <= write_data;
                            l1_state     <= L1_REQ;
                        end
                    end
                end
                L1_REQ: begin
                    if (l1_a_ready) begin
                        l1_a_valid <= 1'b0;
                        l1_d_ready <= 1'b1;
                        l1_state   <= L1_RESP;
                    end
                end
                L1_RESP: begin
                    if (l1_d_valid) begin
                        // Only data belonging to our outstanding request is kept.
                        if (l1_d_opcode == D_ACK_DATA && l1_d_source == l1_a_source) begin
                            read_data <= l1_d_data;
                        end
                        l1_d_ready       <= 1'b0;
                        transaction_done <= 1'b1;
                        l1_state         <= L1_DONE;
                    end
                end
                L1_DONE: l1_state <= L1_IDLE;
                default: l1_state <= L1_IDLE;
            endcase
        end
    end

    // ---------------- L1 <-> L2 link ----------------
`ifdef TL_LINK_BUFFER_EN
    a_chan_t a_slot;
    d_chan_t d_slot;
    logic    a_full;
    logic    d_full;

    assign l1_a_ready   = !a_full || l2_a_ready;
    assign l2_a_valid   = a_full;
    assign l2_a_opcode  = a_slot.opcode;
    assign l2_a_source  = a_slot.source;
    assign l2_a_address = a_slot.address;
    assign l2_a_mask    = a_slot.mask;
    assign l2_a_data    = a_slot.data;

    assign l2_d_ready   = !d_full || l1_d_ready;
    assign l1_d_valid   = d_full;
    assign l1_d_opcode  = d_slot.opcode;
    assign l1_d_source  = d_slot.source;
    assign l1_d_data    = d_slot.data;

    // One-entry slices; a full slot can be refilled in the cycle it drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_full <= 1'b0;
            a_slot <= '0;
            d_full <= 1'b0;
            d_slot <= '0;
        end else begin
            if (l1_a_valid && l1_a_ready) begin
                a_full <= 1'b1;
                a_slot <= '{opcode: l1_a_opcode, source: l1_a_source,
                            address: l1_a_address, mask: l1_a_mask, data: l1_a_data};
            end else if (l2_a_ready) begin
                a_full <= 1'b0;
            end
            if (l2_d_valid && l2_d_ready) begin
                d_full <= 1'b1;
                d_slot <= '{opcode: l2_d_opcode, source: l2_d_source, data: l2_d_data};
            end else if (l1_d_ready) begin
                d_full <= 1'b0;
            end
        end
    end
`else
    assign l2_a_valid   = l1_a_valid;
    assign l2_a_opcode  = l1_a_opcode;
    assign l2_a_source  = l1_a_source;
    assign l2_a_address = l1_a_address;
    assign l2_a_mask    = l1_a_mask;
    assign l2_a_data    = l1_a_data;
    assign l1_a_ready   = l2_a_ready;

    assign l1_d_valid   = l2_d_valid;
    assign l1_d_opcode  = l2_d_opcode;
    assign l1_d_source  = l2_d_source;
    assign l1_d_data    = l2_d_data;
    assign l2_d_ready   = l1_d_ready;
`endif

    // ---------------- L2 slave adapter ----------------
    typedef enum logic {L2_IDLE, L2_RESP} l2_state_t;
    l2_state_t l2_state;

    // Storage keeps each word XOR its power-up pattern (C0DE tag | index);
    // cleared cells therefore read back as the preload image.
    logic [TL_DATA_BITS-1:0] mem_delta [TL_MEM_DEPTH];

    logic                    a_fire;
    logic                    a_is_write;
    logic [TL_IDX_BITS-1:0]  word_idx;
    logic [TL_DATA_BITS-1:0] init_word;
    logic [TL_DATA_BITS-1:0] mem_word;

    assign a_fire     = l2_a_valid && l2_a_ready;
    assign a_is_write = (l2_a_opcode != A_GET);
    assign word_idx   = l2_a_address[TL_OFS_BITS +: TL_IDX_BITS];
    assign init_word  = MEM_INIT_TAG | TL_DATA_BITS'(word_idx);
    assign mem_word   = mem_delta[word_idx] ^ init_word;

    // Byte-masked write at the A handshake; contents are never reset.
    always_ff @(posedge clk) begin
        if (a_fire && a_is_write) begin
            for (int unsigned b = 0; b < TL_DATA_BYTES; b++) begin
                if (l2_a_mask[b]) begin
                    mem_delta[word_idx][8*b +: 8] <= l2_a_data[8*b +: 8] ^ init_word[8*b +: 8];
                end
            end
        end
    end

    // Accept one A beat, answer with one D beat, monitor strobes follow the A handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l2_state        <= L2_IDLE;
            l2_a_ready      <= 1'b1;
            l2_d_valid      <= 1'b0;
            l2_d_opcode     <= '0;
            l2_d_source     <= '0;
            l2_d_data       <= '0;
            mem_write_valid <= 1'b0;
            mem_write_addr  <= '0;
            mem_write_data  <= '0;
            mem_write_mask  <= '0;
            mem_read_valid  <= 1'b0;
            mem_read_addr   <= '0;
            mem_read_data   <= '0;
        end else begin
            mem_write_valid <= 1'b0;
            mem_read_valid  <= 1'b0;
            case (l2_state)
                L2_IDLE: begin
                    if (a_fire) begin
                        l2_a_ready  <= 1'b0;
                        l2_d_valid  <= 1'b1;
                        l2_d_source <= l2_a_source;
                        if (a_is_write) begin
                            l2_d_opcode     <= D_ACK;
                            l2_d_data       <= '0;
                            mem_write_valid <= 1'b1;
                            mem_write_addr  <= l2_a_address;
                            mem_write_data  <= l2_a_data;
                            mem_write_mask  <= l2_a_mask;
                        end else begin
                            // Sub-word GETs still return the whole word.
                            l2_d_opcode    <= D_ACK_DATA;
                            l2_d_data      <= mem_word;
                            mem_read_valid <= 1'b1;
                            mem_read_addr  <= l2_a_address;
                            mem_read_data  <= mem_word;
                        end
                        l2_state <= L2_RESP;
                    end
                end
                L2_RESP: begin
                    if (l2_d_ready) begin
                        l2_d_valid <= 1'b0;
                        l2_a_ready <= 1'b1;
                        l2_state   <= L2_IDLE;
                    end
                end
                default: l2_state <= L2_IDLE;
            endcase
        end
    end

    // ---------------- response monitor ----------------
    assign resp_valid  = l2_d_valid && l2_d_ready;
    assign resp_opcode = l2_d_opcode;
    assign resp_source = l2_d_source;
    assign resp_data   = l2_d_data;

endmodule

// File: tb/tb_tl_link_top.sv
// tb_tl_link_top: directed bench for tl_link_top. Each transaction is observed
// over a fixed window; monitor strobes and done pulses are captured, then
// compared against hand-computed values.
module tb_tl_link_top;

`ifdef TL_LINK_BUFFER_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_transaction;
    logic [1:0]  transaction_type;
    logic        transaction_done;
    logic [31:0] address;
    logic [2:0]  size;
    logic [3:0]  source;
    logic [63:0] write_data;
    logic [7:0]  write_mask;
    logic [63:0] read_data;
    logic        mem_write_valid;
    logic [31:0] mem_write_addr;
    logic [63:0] mem_write_data;
    logic [7:0]  mem_write_mask;
    logic        mem_read_valid;
    logic [31:0] mem_read_addr;
    logic [63:0] mem_read_data;
    logic        resp_valid;
    logic [3:0]  resp_opcode;
    logic [3:0]  resp_source;
    logic [63:0] resp_data;

    tl_link_top dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start_transaction (start_transaction),
        .transaction_type  (transaction_type),
        .transaction_done  (transaction_done),
        .address           (address),
        .size              (size),
        .source            (source),
        .write_data        (write_data),
        .write_mask        (write_mask),
        .read_data         (read_data),
        .mem_write_valid   (mem_write_valid),
        .mem_write_addr    (mem_write_addr),
        .mem_write_data    (mem_write_data),
        .mem_write_mask    (mem_write_mask),
        .mem_read_valid    (mem_read_valid),
        .mem_read_addr     (mem_read_addr),
        .mem_read_data     (mem_read_data),
        .resp_valid        (resp_valid),
        .resp_opcode       (resp_opcode),
        .resp_source       (resp_source),
        .resp_data         (resp_data)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    int          done_cnt, done_lat, wr_cnt, rd_cnt, rsp_cnt;
    logic [31:0] wr_addr, rd_addr;
    logic [63:0] wr_data, rd_data, rsp_data;
    logic [7:0]  wr_mask;
    logic [3:0]  rsp_op, rsp_src;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one command and watch 8 cycles; busy_pulse re-asserts start one cycle later.
    task automatic run(input logic [1:0] ty, input logic [31:0] ad, input logic [2:0] sz,
                       input logic [3:0] src, input logic [63:0] wd, input logic [7:0] wm,
                       input bit busy_pulse);
        @(negedge clk);
        transaction_type  = ty;
        address           = ad;
        size              = sz;
        source            = src;
        write_data        = wd;
        write_mask        = wm;
        start_transaction = 1'b1;
        done_cnt = 0; done_lat = 0; wr_cnt = 0; rd_cnt = 0; rsp_cnt = 0;
        wr_addr = '0; rd_addr = '0; wr_data = '0; rd_data = '0; rsp_data = '0;
        wr_mask = '0; rsp_op = '0; rsp_src = '0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            start_transaction = (c == 1) && busy_pulse;
            if (transaction_done) begin
                done_cnt++;
                if (done_lat == 0) done_lat = c;
            end
            if (mem_write_valid) begin
                wr_cnt++; wr_addr = mem_write_addr; wr_data = mem_write_data; wr_mask = mem_write_mask;
            end
            if (mem_read_valid) begin
                rd_cnt++; rd_addr = mem_read_addr; rd_data = mem_read_data;
            end
            if (resp_valid) begin
                rsp_cnt++; rsp_op = resp_opcode; rsp_src = resp_source; rsp_data = resp_data;
            end
        end
        start_transaction = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_n = 1'b0;
        start_transaction = 1'b0;
        transaction_type = '0; address = '0; size = '0; source = '0;
        write_data = '0; write_mask = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_done",     64'(transaction_done), 64'd0);
        check("rst_read",     read_data,             64'd0);
        check("rst_wvalid",   64'(mem_write_valid),  64'd0);
        check("rst_rvalid",   64'(mem_read_valid),   64'd0);
        check("rst_resp",     64'(resp_valid),       64'd0);
        check("rst_rdata",    mem_read_data,         64'd0);

        // GET 0x10 -> preload word 2
        run(2'd0, 32'h10, 3'd3, 4'd1, 64'd0, 8'h00, 1'b0);
        check("get10_rd_cnt", 64'(rd_cnt),   64'd1);
        check("get10_wr_cnt", 64'(wr_cnt),   64'd0);
        check("get10_rd_addr", 64'(rd_addr), 64'h10);
        check("get10_rd_data", rd_data,      64'hC0DE_0000_0000_0002);
        check("get10_rsp_op",  64'(rsp_op),  64'd1);
        check("get10_rsp_src", 64'(rsp_src), 64'd1);
        check("get10_rsp_data", rsp_data,    64'hC0DE_0000_0000_0002);
        check("get10_read",    read_data,    64'hC0DE_0000_0000_0002);
        check("get10_lat",     64'(done_lat), 64'(LAT));
        check("get10_ndone",   64'(done_cnt), 64'd1);

        // PUTFULL 0x20
        run(2'd1, 32'h20, 3'd3, 4'd2, 64'h1122_3344_5566_7788, 8'h00, 1'b0);
        check("put20_wr_cnt",  64'(wr_cnt),   64'd1);
        check("put20_rd_cnt",  64'(rd_cnt),   64'd0);
        check("put20_addr",    64'(wr_addr),  64'h20);
        check("put20_mask",    64'(wr_mask),  64'hFF);
        check("put20_data",    wr_data,       64'h1122_3344_5566_7788);
        check("put20_rsp_op",  64'(rsp_op),   64'd0);
        check("put20_rsp_src", 64'(rsp_src),  64'd2);
        check("put20_read",    read_data,     64'hC0DE_0000_0000_0002);
        check("put20_lat",     64'(done_lat), 64'(LAT));

        run(2'd0, 32'h20, 3'd3, 4'd3, 64'd0, 8'h00, 1'b0);
        check("get20a_read",   read_data,     64'h1122_3344_5566_7788);
        check("get20a_rsp_src", 64'(rsp_src), 64'd3);

        // PUTPARTIAL low half
        run(2'd2, 32'h20, 3'd3, 4'd4, 64'hFFFF_FFFF_AABB_CCDD, 8'h0F, 1'b0);
        check("pp20_mask",     64'(wr_mask),  64'h0F);
        check("pp20_rsp_op",   64'(rsp_op),   64'd0);
        run(2'd0, 32'h20, 3'd3, 4'd4, 64'd0, 8'h00, 1'b0);
        check("get20b_read",   read_data,     64'h1122_3344_AABB_CCDD);

        // Address wraps: 0x2020 maps to word 4
        run(2'd0, 32'h2020, 3'd3, 4'd6, 64'd0, 8'h00, 1'b0);
        check("wrap_rd_addr",  64'(rd_addr),  64'h2020);
        check("wrap_read",     read_data,     64'h1122_3344_AABB_CCDD);

        // Sub-word PUTFULL: 2 bytes at offset 2
        run(2'd1, 32'h42, 3'd1, 4'd5, 64'h0000_0000_BEEF_0000, 8'h00, 1'b0);
        check("put42_mask",    64'(wr_mask),  64'h0C);
        check("put42_addr",    64'(wr_addr),  64'h42);
        run(2'd0, 32'h40, 3'd3, 4'd5, 64'd0, 8'h00, 1'b0);
        check("get40_read",    read_data,     64'hC0DE_0000_BEEF_0008);

        // Start pulsed again while busy
        run(2'd0, 32'h10, 3'd3, 4'd1, 64'd0, 8'h00, 1'b1);
        check("busy_ndone",    64'(done_cnt), 64'd1);
        check("busy_rd_cnt",   64'(rd_cnt),   64'd1);
        check("busy_read",     read_data,     64'hC0DE_0000_0000_0002);

        // Reserved type: immediate done, no traffic
        run(2'd3, 32'h30, 3'd3, 4'd7, 64'hDEAD, 8'hFF, 1'b0);
        check("t3_lat",        64'(done_lat), 64'd1);
        check("t3_ndone",      64'(done_cnt), 64'd1);
        check("t3_wr_cnt",     64'(wr_cnt),   64'd0);
        check("t3_rd_cnt",     64'(rd_cnt),   64'd0);
        check("t3_rsp_cnt",    64'(rsp_cnt),  64'd0);
        check("t3_read",       read_data,     64'hC0DE_0000_0000_0002);

        // Reset while the request is pending
        @(negedge clk);
        transaction_type = 2'd0; address = 32'h18; size = 3'd3; source = 4'd9;
        start_transaction = 1'b1;
        @(negedge clk);
        start_transaction = 1'b0;
        check("mid_a_valid",   64'(dut.l1_a_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_done",      64'(transaction_done), 64'd0);
        check("mid_read",      read_data,             64'd0);
        check("mid_rvalid",    64'(mem_read_valid),   64'd0);
        check("mid_rdata",     mem_read_data,         64'd0);
        check("mid_resp",      64'(resp_valid),       64'd0);
        check("mid_rsp_op",    64'(resp_opcode),      64'd0);
        check("mid_rsp_data",  resp_data,             64'd0);
        check("mid_a_valid0",  64'(dut.l1_a_valid),   64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run(2'd0, 32'h18, 3'd3, 4'd9, 64'd0, 8'h00, 1'b0);
        check("post_read",     read_data,     64'hC0DE_0000_0000_0003);
        check("post_lat",      64'(done_lat), 64'(LAT));
        check("post_ndone",    64'(done_cnt), 64'd1);
        check("post_rsp_src",  64'(rsp_src),  64'd9);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
